// File: rtl/if_stage.sv
// if_stage: instruction fetch stage driving the instruction ROM and the IF/ID register.
// Handles stall, branch redirect (held pending across stall_if) and flush.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              misalign_err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, id_pc_n, pend_target, pend_target_n, target;
    logic [INST_W-1:0] id_inst_n;
    logic              id_valid_n, pend_valid, pend_valid_n, misalign_n;
    // A fresh branch takes precedence over an older pending one
    assign target   = branch_flag ? {branch_target[ADDR_W-1:2], 2'b00} : pend_target;
    assign rom_addr = pc;
    assign rom_ce   = state == RUN;
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        id_pc_n       = id_pc;
        id_inst_n     = id_inst;
        id_valid_n    = id_valid;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;
        misalign_n    = 1'b0;
        if (state == IDLE) begin
            state_n = RUN;
        end else if (flush) begin
            pc_n         = {flush_pc[ADDR_W-1:2], 2'b00};
            id_inst_n    = '0;
            id_valid_n   = 1'b0;
            pend_valid_n = 1'b0;
            misalign_n   = |flush_pc[1:0];
        end else begin
            misalign_n = branch_flag & |branch_target[1:0];
            if (branch_flag || pend_valid) begin
                pc_n          = stall_if ? pc : target;
                pend_valid_n  = stall_if;
                pend_target_n = stall_if ? target : pend_target;
                id_inst_n     = stall_id ? id_inst : '0;
                id_valid_n    = stall_id & id_valid;
            end else if (stall_if) begin
                id_inst_n  = stall_id ? id_inst : '0;
                id_valid_n = stall_id & id_valid;
            end else if (!stall_id) begin
                pc_n       = pc + ADDR_W'(4);
                id_pc_n    = pc;
                id_inst_n  = rom_inst;
                id_valid_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            id_pc        <= '0;
            id_inst      <= '0;
            id_valid     <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            id_pc        <= id_pc_n;
            id_inst      <= id_inst_n;
            id_valid     <= id_valid_n;
            pend_valid   <= pend_valid_n;
            pend_target  <= pend_target_n;
            misalign_err <= misalign_n;
        end
    end
endmodule
